// File: rtl/counter_pkg.sv
// Shared constants for the counter family: FSM state encoding and default width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t RUN  = 2'b01;
  localparam state_t DONE = 2'b10;

endpackage

// File: rtl/counter_down_load.sv
// Loadable down-counter/timer: counts a loaded value to zero, pulses tc,
// then either parks in DONE (one-shot) or reloads and keeps running (periodic).
module counter_down_load
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
    end
  end

  // Priority per cycle: load > stop > start > decrement.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;

    if (load) begin
      reload_nxt = data;
      count_nxt  = data;
      state_nxt  = IDLE;
    end else if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && count != '0) state_nxt = RUN;
        end
        DONE: begin
          if (start && reload_reg != '0) begin
            count_nxt = reload_reg;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (count == WIDTH'(1)) begin
              tc_nxt = 1'b1;
              if (auto_reload) begin
                count_nxt = reload_reg;
              end else begin
                count_nxt = '0;
                state_nxt = DONE;
              end
            end else if (count != '0) begin
              // Guarded so a zero count never wraps to all-ones.
              count_nxt = count - WIDTH'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_counter_down_load.sv
// Self-checking bench for counter_down_load: directed scenarios plus a random
// phase, all compared against a behavioural model of the counter's rules.
module tb_counter_down_load;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load, start, stop, en, auto_reload;
  logic [W-1:0] data;
  logic [W-1:0] count;
  logic         tc, busy, done;

  int total = 0;
  int bad   = 0;

  // Behavioural model: remaining count, reload value and a coarse mode.
  int m_count, m_reload;
  bit m_running, m_finished, m_tc;

  counter_down_load #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .start(start),
    .stop(stop), .en(en), .auto_reload(auto_reload),
    .count(count), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_count = 0; m_reload = 0; m_running = 0; m_finished = 0; m_tc = 0;
  endfunction

  // One clock edge of the timer, from the rules: load aborts, stop freezes,
  // start arms (or re-arms from the reload value), enabled running counts down.
  function automatic void model_edge();
    m_tc = 0;
    if (load) begin
      m_reload = int'(data); m_count = int'(data);
      m_running = 0; m_finished = 0;
    end else if (stop) begin
      m_running = 0; m_finished = 0;
    end else if (start && !m_running) begin
      if (m_finished && m_reload != 0) begin
        m_count = m_reload; m_running = 1; m_finished = 0;
      end else if (!m_finished && m_count != 0) begin
        m_running = 1;
      end
    end else if (m_running && en && m_count > 0) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_tc = 1;
        if (auto_reload) m_count = m_reload;
        else begin m_running = 0; m_finished = 1; end
      end
    end
  endfunction

  task automatic drive(input logic l, input logic [W-1:0] d, input logic s,
                       input logic sp, input logic e, input logic ar);
    load = l; data = d; start = s; stop = sp; en = e; auto_reload = ar;
  endtask

  // Advance one edge, update the model, then sample away from the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".tc"},    32'(tc),    32'(m_tc));
    check({tag, ".busy"},  32'(busy),  32'(m_running));
    check({tag, ".done"},  32'(done),  32'(m_finished));
  endtask

  initial begin
    int pulses;
    int seen_done;

    rst = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0);
    model_reset();
    #12;
    check("por.count", 32'(count), 0);
    check("por.busy", 32'(busy), 0);
    check("por.done", 32'(done), 0);
    check("por.tc", 32'(tc), 0);
    rst = 1'b1;

    // Asynchronous reset in the middle of a countdown at 0x37.
    drive(1, 8'h38, 0, 0, 0, 0); step("rst.load");
    drive(0, 8'h00, 1, 0, 1, 0); step("rst.start");
    drive(0, 8'h00, 0, 0, 1, 0); step("rst.dec");
    check("rst.pre_count", 32'(count), 32'h37);
    check("rst.pre_busy", 32'(busy), 1);
    #3 rst = 1'b0;
    #1;
    check("rst.async_count", 32'(count), 0);
    check("rst.async_busy", 32'(busy), 0);
    check("rst.async_done", 32'(done), 0);
    check("rst.async_tc", 32'(tc), 0);
    model_reset();
    #2 rst = 1'b1;

    // One-shot from 5.
    drive(1, 8'd5, 0, 0, 0, 0); step("os.load");
    drive(0, 8'd0, 1, 0, 1, 0); step("os.start");
    check("os.run_count", 32'(count), 5);
    drive(0, 8'd0, 0, 0, 1, 0);
    for (int i = 4; i >= 0; i--) begin
      step("os.count");
      check("os.seq", 32'(count), 32'(i));
    end
    check("os.tc_at_zero", 32'(tc), 1);
    check("os.done", 32'(done), 1);
    check("os.busy", 32'(busy), 0);
    for (int i = 0; i < 10; i++) step("os.hold");
    check("os.hold_count", 32'(count), 0);

    // Periodic from 3, four periods.
    drive(1, 8'd3, 0, 0, 1, 1); step("per.load");
    drive(0, 8'd0, 1, 0, 1, 1); step("per.start");
    drive(0, 8'd0, 0, 0, 1, 1);
    pulses = 0; seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      step("per.run");
      check("per.seq", 32'(count), 32'(3 - ((i + 1) % 3)));
      pulses += int'(tc);
      seen_done += int'(done);
    end
    check("per.pulses", 32'(pulses), 4);
    check("per.no_done", 32'(seen_done), 0);

    // Pause with en toggling, then stop at 6 and resume.
    drive(1, 8'd10, 0, 0, 0, 0); step("ps.load");
    drive(0, 8'd0, 1, 0, 1, 0); step("ps.start");
    for (int i = 0; i < 7; i++) begin
      drive(0, 8'd0, 0, 0, logic'(i % 2 == 0), 0);
      step("ps.toggle");
    end
    check("ps.at6", 32'(count), 6);
    drive(0, 8'd0, 0, 1, 1, 0); step("ps.stop");
    check("ps.stop_count", 32'(count), 6);
    check("ps.stop_busy", 32'(busy), 0);
    drive(0, 8'd0, 1, 0, 1, 0); step("ps.resume");
    drive(0, 8'd0, 0, 0, 1, 0); step("ps.dec");
    check("ps.at5", 32'(count), 5);

    // Conflicts.
    drive(1, 8'd8, 1, 0, 1, 0); step("cf.load_start");
    check("cf.ls_count", 32'(count), 8);
    check("cf.ls_busy", 32'(busy), 0);
    drive(0, 8'd0, 1, 0, 1, 0); step("cf.start");
    drive(0, 8'd0, 0, 0, 1, 0); step("cf.dec");
    drive(0, 8'd0, 1, 0, 1, 0); step("cf.restart");
    check("cf.no_restart", 32'(count), 6);
    drive(1, 8'd0, 0, 0, 0, 0); step("cf.load0");
    drive(0, 8'd0, 1, 0, 1, 0); step("cf.start0");
    check("cf.zero_busy", 32'(busy), 0);
    check("cf.zero_tc", 32'(tc), 0);

    // DONE restart from 2, then full-width countdown from 0xFF.
    drive(1, 8'd2, 0, 0, 0, 0); step("dn.load");
    drive(0, 8'd0, 1, 0, 1, 0); step("dn.start");
    drive(0, 8'd0, 0, 0, 1, 0); step("dn.dec1"); step("dn.dec0");
    check("dn.done", 32'(done), 1);
    drive(0, 8'd0, 1, 0, 1, 0); step("dn.restart");
    check("dn.restart_count", 32'(count), 2);
    check("dn.restart_busy", 32'(busy), 1);
    drive(1, 8'hFF, 0, 0, 0, 0); step("ff.load");
    drive(0, 8'd0, 1, 0, 1, 0); step("ff.start");
    drive(0, 8'd0, 0, 0, 1, 0);
    for (int i = 0; i < 255; i++) step("ff.run");
    check("ff.zero", 32'(count), 0);
    check("ff.done", 32'(done), 1);
    for (int i = 0; i < 3; i++) step("ff.nowrap");
    check("ff.nowrap_count", 32'(count), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      drive(logic'($urandom_range(0, 99) < 6), d,
            logic'($urandom_range(0, 99) < 15),
            logic'($urandom_range(0, 99) < 3),
            logic'($urandom_range(0, 99) < 75),
            logic'($urandom_range(0, 1)));
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_down_load.md
Name: counter_down_load

Overview:
- Loadable down-counter/timer: the down-counting counterpart of the team's up counter with load option.
- Counts a loaded value down to zero, flags terminal count, and either stops (one-shot) or reloads (periodic).
- Serves as a programmable delay/timeout or rate generator for control logic in the same designs.
- Single clock domain; controlled by a three-state FSM.

Parameters:
- WIDTH, 8, width of data, count and the internal reload register.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- load  input  1  capture data into the reload register and count
- data  input  WIDTH  load value
- start  input  1  begin or restart a countdown
- stop  input  1  abort a countdown, holding count
- en  input  1  count enable; 0 pauses while running
- auto_reload  input  1  0 = one-shot, 1 = periodic
- count  output  WIDTH  current count value
- tc  output  1  terminal-count pulse, one cycle
- busy  output  1  high in RUN
- done  output  1  high in DONE (one-shot finished)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Reset (rst=0, asynchronous, immediate, including mid-count): count=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0.
- All outputs are registered or decoded from state only; busy and done are decoded from state.
- States:
  - IDLE: count holds.
  - RUN: counting.
  - DONE: count=0, waiting.
- Per-cycle priority: load > stop > start > decrement.
- load=1 (any state): reload_reg<=data, count<=data, state<=IDLE, tc<=0. This aborts any countdown in progress.
- stop=1 (no load): state<=IDLE, count holds, tc<=0.
- start in IDLE:
  - if count!=0: state<=RUN, count unchanged.
  - if count==0: stay in IDLE; no tc.
- start in DONE:
  - if reload_reg!=0: count<=reload_reg, state<=RUN.
  - else: stay in DONE.
- start in RUN: ignored.
- RUN with en=0: count holds, tc<=0.
- RUN with en=1 and count>1: count<=count-1, tc<=0.
- RUN with en=1 and count==1: tc<=1 (pulse visible for exactly one cycle), then:
  - auto_reload=0: count<=0, state<=DONE.
  - auto_reload=1: count<=reload_reg, stay in RUN. Period = reload value N enabled cycles.
- tc is low in every other cycle, including while paused.
- auto_reload is sampled only at the count==1 decision cycle.
- No wrap-around: count never decrements below 0; the 0 to all-ones transition is illegal.
- Latency: after start, the first decrement is on the next enabled edge. With load N, start, and en held high, tc rises N cycles after RUN is entered.
- Simultaneous load+start: load wins; start is dropped and the state is IDLE.
- Simultaneous stop+start: stop wins.

Decomposition:
- Shared package counter_pkg:
  - state encoding localparams: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - default WIDTH constant.
- Single module; no sub-module needed.
- The next-state/next-count logic stays in one combinational block, separate from the registers.

Test Plan:
1. Reset/load: assert rst=0 mid-RUN with count=0x37 -> count=0, busy=0, done=0, tc=0 immediately, without waiting for a clock edge.
2. One-shot: load data=5, start, en=1 -> count 5,4,3,2,1,0; tc high for one cycle, coincident with count=0; done=1, busy=0; count stays 0 for the next 10 cycles.
3. Periodic: load 3, auto_reload=1, en=1 -> count sequence 3,2,1,3,2,1...; tc pulse every 3 cycles, observed for 4 periods; done never asserts.
4. Pause/stop: load 10, start, en toggles 1/0 -> count decrements only on en=1 cycles; stop at count=6 -> IDLE with count=6; start resumes 6->5.
5. Conflicts: load 8 and start in the same cycle -> IDLE with count=8; start in RUN does not restart; load 0 then start -> stays IDLE, no tc.
6. DONE restart: after a one-shot from 2 finishes, start -> count=2, RUN; WIDTH=8 load 0xFF counts to 0 with no wrap to 0xFF.
